serial_compare_scheduler: RTL

//  Shares one MSB-first serial comparator between N_REQ requesters, using round-robin arbitration.
//  - Accepts parallel operand pairs (a, b) over a valid/ready handshake.
//  - Shifts the pair into the comparator one bit per clock, MSB first.
//  - Returns a one-hot less/equal/greater result, tagged with the requester id.

---
 rtl/serial_cmp_pkg.sv | 21 ++
 rtl/serial_comparator_most_significant_first.sv | 37 +++
 rtl/serial_compare_scheduler.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/serial_cmp_pkg.sv
// Shared types for the serial compare scheduler and its bit-serial comparator.
package serial_cmp_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        RESP  = 2'd2
    } sched_state_t;

    typedef struct packed {
        logic lt;
        logic eq;
        logic gt;
    } cmp_result_t;

    // Index width that stays >= 1 so single-entry ranges remain legal.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/serial_comparator_most_significant_first.sv
// MSB-first bit-serial unsigned comparator; the first differing bit decides the result.
module serial_comparator_most_significant_first
    import serial_cmp_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        bit_valid_i,
    input  logic        a_bit_i,
    input  logic        b_bit_i,
    output cmp_result_t res_o
);

    logic lt_q;
    logic gt_q;
    logic undecided;

    assign undecided = ~lt_q & ~gt_q;

    // Outputs already include the bit on the inputs, so a decision is visible in the shift cycle.
    always_comb begin
        res_o    = '0;
        res_o.lt = lt_q | (undecided & ~a_bit_i & b_bit_i);
        res_o.gt = gt_q | (undecided & a_bit_i & ~b_bit_i);
        res_o.eq = ~res_o.lt & ~res_o.gt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lt_q <= 1'b0;
            gt_q <= 1'b0;
        end else if (bit_valid_i) begin
            lt_q <= res_o.lt;
            gt_q <= res_o.gt;
        end
    end

endmodule

// File: rtl/serial_compare_scheduler.sv
// Round-robin front end sharing one MSB-first serial comparator among N_REQ requesters.
module serial_compare_scheduler
    import serial_cmp_pkg::*;
#(
    parameter int unsigned WIDTH      = 8,
    parameter int unsigned N_REQ      = 4,
    parameter bit          EARLY_EXIT = 1'b1,
    parameter int unsigned ID_W       = idx_width(N_REQ)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_REQ-1:0]         req_valid,
    output logic [N_REQ-1:0]         req_ready,
    input  logic [N_REQ*WIDTH-1:0]   req_a,
    input  logic [N_REQ*WIDTH-1:0]   req_b,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [ID_W-1:0]          rsp_id,
    output logic                     rsp_lt,
    output logic                     rsp_eq,
    output logic                     rsp_gt,
    output logic                     busy
);

    localparam int unsigned IDX_W = idx_width(WIDTH);

    sched_state_t     state_q, state_d;
    logic [ID_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic [ID_W-1:0]  id_q, id_d;
    logic [ID_W-1:0]  rsp_id_q, rsp_id_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [IDX_W-1:0] bit_idx_q, bit_idx_d;
    cmp_result_t      rsp_q, rsp_d;
    cmp_result_t      cmp_res;

    logic [ID_W-1:0]  grant;
    logic [ID_W-1:0]  cand;
    logic             any_valid;
    logic             accept;
    logic             shift_en;

    logic [WIDTH-1:0] op_a [N_REQ];
    logic [WIDTH-1:0] op_b [N_REQ];

    for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
        assign op_a[g] = req_a[g*WIDTH +: WIDTH];
        assign op_b[g] = req_b[g*WIDTH +: WIDTH];
    end

    // Walk upward from rr_ptr with wrap; the first valid candidate wins.
    always_comb begin
        grant     = '0;
        any_valid = 1'b0;
        cand      = rr_ptr_q;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (!any_valid && req_valid[cand]) begin
                grant     = cand;
                any_valid = 1'b1;
            end
            cand = (cand == ID_W'(N_REQ - 1)) ? '0 : cand + 1'b1;
        end
    end

    always_comb begin
        state_d   = state_q;
        rr_ptr_d  = rr_ptr_q;
        id_d      = id_q;
        rsp_id_d  = rsp_id_q;
        a_d       = a_q;
        b_d       = b_q;
        bit_idx_d = bit_idx_q;
        rsp_d     = rsp_q;
        req_ready = '0;
        accept    = 1'b0;
        shift_en  = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (!rst && any_valid) begin
                    req_ready[grant] = 1'b1;
                    accept           = 1'b1;
                    a_d              = op_a[grant];
                    b_d              = op_b[grant];
                    id_d             = grant;
                    bit_idx_d        = IDX_W'(WIDTH - 1);
                    rr_ptr_d         = (grant == ID_W'(N_REQ - 1)) ? '0 : grant + 1'b1;
                    state_d          = SHIFT;
                end
            end
            SHIFT: begin
                shift_en  = 1'b1;
                bit_idx_d = bit_idx_q - 1'b1;
                if ((bit_idx_q == '0) || (EARLY_EXIT && !cmp_res.eq)) begin
                    rsp_d    = cmp_res;
                    rsp_id_d = id_q;
                    state_d  = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            rr_ptr_q  <= '0;
            id_q      <= '0;
            rsp_id_q  <= '0;
            a_q       <= '0;
            b_q       <= '0;
            bit_idx_q <= '0;
            rsp_q     <= '0;
        end else begin
            state_q   <= state_d;
            rr_ptr_q  <= rr_ptr_d;
            id_q      <= id_d;
            rsp_id_q  <= rsp_id_d;
            a_q       <= a_d;
            b_q       <= b_d;
            bit_idx_q <= bit_idx_d;
            rsp_q     <= rsp_d;
        end
    end

    serial_comparator_most_significant_first u_cmp (
        .clk         (clk),
        .rst         (rst | accept),
        .bit_valid_i (shift_en),
        .a_bit_i     (a_q[bit_idx_q]),
        .b_bit_i     (b_q[bit_idx_q]),
        .res_o       (cmp_res)
    );

    assign rsp_valid = (state_q == RESP);
    assign busy      = (state_q != IDLE);
    assign rsp_id    = rsp_id_q;
    assign rsp_lt    = rsp_q.lt;
    assign rsp_eq    = rsp_q.eq;
    assign rsp_gt    = rsp_q.gt;

endmodule
